// File: rtl/matc_writeback_pkg.sv
// Shared matmul definitions for the matrix C writeback path: state
// encoding, default result-matrix geometry and a block-count helper.
package matc_writeback_pkg;

    localparam int ROW_SIZE_MAT_C = 16;
    localparam int COL_SIZE_MAT_C = 10;
    localparam int BLOCK_SIZE_C   = 2;
    localparam int TOTAL_BLOCKS   = (ROW_SIZE_MAT_C / BLOCK_SIZE_C) * (COL_SIZE_MAT_C / BLOCK_SIZE_C);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_t;

    // Number of systolic blocks along one matrix dimension.
    function automatic int blocks_along(input int elems, input int block_size);
        return elems / block_size;
    endfunction

endpackage

// File: rtl/matc_writeback_if.sv
// Result-block input stream and C-memory write bus. The master modport is
// the writeback engine; the slave modport is its surrounding environment.
interface matc_writeback_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  in_valid, in_data, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );

    modport slave (
        output in_valid, in_data, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/matc_writeback_block_fifo.sv
// Synchronous result-block FIFO with a combinational head and full/empty
// flags. A push while full is refused even if a pop happens that cycle.
module block_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W:0]        count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push && !(rst || clr)) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/matc_writeback.sv
// Matrix C writeback engine: buffers result blocks from the systolic array
// and writes them to C memory in row-major block order, one address per block.
module matc_writeback
    import matc_writeback_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int CHUNK_SIZE     = 4,
    parameter int BLOCK_SIZE     = 2,
    parameter int ROW_SIZE_MAT_A = 16,
    parameter int COL_SIZE_MAT_B = 10,
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    matc_writeback_if.master bus,
    output logic busy,
    output logic done,
    output logic overflow_err
);
    localparam int BLK_ROWS = blocks_along(ROW_SIZE_MAT_A, BLOCK_SIZE);
    localparam int BLK_COLS = blocks_along(COL_SIZE_MAT_B, BLOCK_SIZE);

    wb_state_t                     state;
    logic [ADDR_WIDTH-1:0]         blk_row;
    logic [ADDR_WIDTH-1:0]         blk_col;
    logic [WIDTH*CHUNK_SIZE-1:0]   fifo_head;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          start_accept;
    logic                          push;
    logic                          pop;
    logic                          last_blk;
    logic                          last_col;

    assign start_accept = start && (state != ST_RUN);
    assign bus.in_ready = (state == ST_RUN) && !fifo_full;
    assign push         = bus.in_valid && bus.in_ready;
    assign bus.wr_valid = (state == ST_RUN) && !fifo_empty;
    assign bus.wr_data  = fifo_head;
    assign pop          = bus.wr_valid && bus.wr_ready;
    assign bus.wr_addr  = blk_row * ADDR_WIDTH'(BLOCK_SIZE * COL_SIZE_MAT_B)
                        + blk_col * ADDR_WIDTH'(BLOCK_SIZE);
    assign last_col     = (blk_col == ADDR_WIDTH'(BLK_COLS - 1));
    assign last_blk     = last_col && (blk_row == ADDR_WIDTH'(BLK_ROWS - 1));

    block_fifo #(
        .DATA_WIDTH (WIDTH * CHUNK_SIZE),
        .DEPTH      (FIFO_DEPTH)
    ) u_block_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_accept),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pass control: state, block position, and the registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            blk_row      <= '0;
            blk_col      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state        <= ST_RUN;
                        blk_row      <= '0;
                        blk_col      <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        overflow_err <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.in_valid && !bus.in_ready) overflow_err <= 1'b1;
                    if (pop) begin
                        if (last_blk) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (last_col) begin
                            blk_col <= '0;
                            blk_row <= blk_row + ADDR_WIDTH'(1);
                        end else begin
                            blk_col <= blk_col + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matc_writeback.sv
// Bench for matc_writeback: random block traffic and write back-pressure
// checked cycle by cycle against a queue-based model of the writeback pass.
module tb_matc_writeback;

    localparam int DW         = 64;
    localparam int AW         = 16;
    localparam int BLK_COLS   = 10 / 2;
    localparam int TOTAL      = (16 / 2) * (10 / 2);
    localparam int DEPTH      = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic overflow_err;

    matc_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    matc_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus.master),
        .busy         (busy),
        .done         (done),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int          vectors    = 0;
    int          miscompares = 0;
    bit          active     = 1'b0;
    bit          doneFlag   = 1'b0;
    bit          ovfFlag    = 1'b0;
    int          blkIdx     = 0;
    logic [DW-1:0] q [$];

    // Element address of block number idx in row-major block order.
    function automatic logic [AW-1:0] refAddr(input int idx);
        int row;
        int col;
        row = idx / BLK_COLS;
        col = idx % BLK_COLS;
        return AW'(row * 2 * 10 + col * 2);
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic applyStimulus(input logic s, input logic v, input logic r, input logic rs);
        logic [DW-1:0] d;
        bit            wasActive;
        bit            canPush;
        bit            expVld;
        d = {$urandom, $urandom};
        start        = s;
        bus.in_valid = v;
        bus.wr_ready = r;
        bus.in_data  = d;
        rst          = rs;
        #1;
        canPush = active && (q.size() < DEPTH);
        expVld  = active && (q.size() > 0);
        checkOutput("busy", {63'd0, busy}, {63'd0, active});
        checkOutput("done", {63'd0, done}, {63'd0, doneFlag});
        checkOutput("overflow_err", {63'd0, overflow_err}, {63'd0, ovfFlag});
        checkOutput("in_ready", {63'd0, bus.in_ready}, {63'd0, canPush});
        checkOutput("wr_valid", {63'd0, bus.wr_valid}, {63'd0, expVld});
        checkOutput("wr_addr", {48'd0, bus.wr_addr}, {48'd0, refAddr(blkIdx)});
        if (expVld) checkOutput("wr_data", bus.wr_data, q[0]);
        if (rs) begin
            active   = 1'b0;
            doneFlag = 1'b0;
            ovfFlag  = 1'b0;
            blkIdx   = 0;
            q.delete();
        end else begin
            wasActive = active;
            if (active && v && !canPush) ovfFlag = 1'b1;
            if (expVld && r) begin
                void'(q.pop_front());
                if (blkIdx == TOTAL - 1) begin
                    active   = 1'b0;
                    doneFlag = 1'b1;
                end else begin
                    blkIdx++;
                end
            end
            if (canPush && v) q.push_back(d);
            if (s && !wasActive) begin
                active   = 1'b1;
                doneFlag = 1'b0;
                ovfFlag  = 1'b0;
                blkIdx   = 0;
                q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Random traffic until the pass ends or block stopIdx is reached.
    task automatic runRandom(input int maxCycles, input int stopIdx, input int vPct, input int rPct);
        int i;
        for (i = 0; i < maxCycles; i++) begin
            if (!active || blkIdx >= stopIdx) break;
            applyStimulus(1'b0, int'($urandom_range(99)) < vPct, int'($urandom_range(99)) < rPct, 1'b0);
        end
        if (i == maxCycles) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL cycle_budget observed=%0d expected<%0d", i, maxCycles);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, then idle with traffic offered.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

        // Full pass with the write side always ready.
        $display("[TB] pass A: free-flowing writes");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        runRandom(400, TOTAL, 80, 100);
        checkOutput("passA_done", {63'd0, done}, 64'd1);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

        // Restart from DONE, then stall writes to overflow the buffer.
        $display("[TB] pass B: overflow, push/pop overlap, ignored start");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        runRandom(400, 10, 60, 60);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        runRandom(800, TOTAL, 60, 60);
        checkOutput("passB_done", {63'd0, done}, 64'd1);

        // Reset in the middle of a pass with blocks backed up.
        $display("[TB] pass C: reset mid-pass then clean pass");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runRandom(800, 17, 90, 40);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        runRandom(800, TOTAL, 70, 70);
        checkOutput("passC_done", {63'd0, done}, 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matc_writeback.md
MATC_WRITEBACK -- requirements
Module: matc_writeback

Interface
REQ-001 SHALL have parameters (name, default, meaning): WIDTH, 16, element bit width.
REQ-002 SHALL have parameter CHUNK_SIZE, 4, elements per result block (BLOCK_SIZE*BLOCK_SIZE).
REQ-003 SHALL have parameter BLOCK_SIZE, 2, systolic block dimension.
REQ-004 SHALL have parameters ROW_SIZE_MAT_A, 16, and COL_SIZE_MAT_B, 10, result matrix C element dimensions.
REQ-005 SHALL have parameter FIFO_DEPTH, 4, result-block buffer depth (power of two).
REQ-006 SHALL have parameter ADDR_WIDTH, 16, write address width.
REQ-007 SHALL have ports (name, direction, width, meaning): clk  in  1  sole clock.
REQ-008 rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-009 start  in  1  begin a matrix C writeback pass.
REQ-010 in_valid  in  1  core result block present (driven from accumulator_done).
REQ-011 in_data  in  WIDTH*CHUNK_SIZE  result block, element 0 in LSBs.
REQ-012 in_ready  out  1  block accepted this cycle when high with in_valid.
REQ-013 wr_valid  out  1  write request to C memory.
REQ-014 wr_ready  in  1  C memory accepts write.
REQ-015 wr_addr  out  ADDR_WIDTH  element address of block top-left element, row-major in C.
REQ-016 wr_data  out  WIDTH*CHUNK_SIZE  block payload.
REQ-017 busy  out  1  pass in progress; done  out  1  pass complete; overflow_err  out  1  sticky drop flag.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE on handshake of last block, DONE->RUN on start.
REQ-019 SHALL ignore start while in RUN.
REQ-020 SHALL clear block counters (blk_row, blk_col) and FIFO on entering RUN.
REQ-021 SHALL assert in_ready in RUN only when FIFO not full; in_ready=0 in IDLE and DONE.
REQ-022 SHALL push in_data on in_valid&&in_ready; in_valid while in_ready=0 in RUN SHALL drop the block and set overflow_err until rst or start.
REQ-023 SHALL drive wr_valid = RUN && FIFO not empty, wr_data = FIFO head, both combinational from FIFO state, stable until wr_ready.
REQ-024 SHALL pop and advance counters on wr_valid&&wr_ready.
REQ-025 SHALL compute wr_addr = blk_row*BLOCK_SIZE*COL_SIZE_MAT_B + blk_col*BLOCK_SIZE, zero-extended/truncated to ADDR_WIDTH.
REQ-026 SHALL advance blk_col 0..COL_SIZE_MAT_B/BLOCK_SIZE-1, wrap to 0 and increment blk_row; final block is blk_row=ROW_SIZE_MAT_A/BLOCK_SIZE-1, blk_col=COL_SIZE_MAT_B/BLOCK_SIZE-1.
REQ-027 SHALL allow simultaneous push and pop in one cycle, occupancy unchanged; push when full blocked even if pop occurs same cycle.
REQ-028 SHALL have minimum latency one cycle from accepted in_valid to wr_valid.
REQ-029 SHALL assert done one cycle after final handshake, holding until start or rst; busy = state RUN.
REQ-030 SHALL discard blocks remaining in FIFO after final handshake (none expected); in_valid in DONE ignored, no overflow_err.

Reset
REQ-031 SHALL on rst: state IDLE, counters 0, FIFO empty, in_ready=0, wr_valid=0, wr_addr=0, busy=0, done=0, overflow_err=0.
REQ-032 SHALL honor rst mid-pass in one cycle, abandoning queued blocks without further writes.

Structure
REQ-033 SHALL place state encoding and derived constants ROW_SIZE_MAT_C, COL_SIZE_MAT_C, TOTAL_BLOCKS in a shared matmul package.
REQ-034 SHALL instantiate one sub-module block_fifo (synchronous, parameterised WIDTH*CHUNK_SIZE x FIFO_DEPTH, full/empty flags).

Verification (defaults: C blocks 8x5=40)
REQ-035 rst, start, 40 blocks with wr_ready=1 -> wr_addr sequence 0,2,4,6,8,20,...,148; done high one cycle after block 40.
REQ-036 Block 5 (blk_row1, blk_col0) -> wr_addr=20; block 4 -> wr_addr=8.
REQ-037 wr_ready=0 for 10 cycles, in_valid every cycle -> in_ready low after 4 accepts, 5th block dropped, overflow_err=1, wr_data held stable.
REQ-038 FIFO holding 2, push and pop same cycle -> occupancy stays 2, data order preserved.
REQ-039 rst at block 17 with 3 queued -> wr_valid=0 next cycle, all outputs at reset values, next start writes from wr_addr 0.
REQ-040 start pulsed during RUN at block 10 -> ignored, counters continue; start in DONE -> done=0, overflow_err=0, new pass from address 0.
